ahb_output_arbiter: RTL and testbench

Parametrised output-stage arbiter for the AHB bus matrix. One instance sits in front of each shared slave port and decides which input port owns the slave's address phase. It generalises the single-port arbiter in three ways:
- the number of input ports is set by `NUM_PORTS`;
- it adds a selectable fixed-priority mode alongside round-robin;
- it exposes a one-hot grant vector and a configurable INCR early-termination limit.

---
 rtl/ahb_output_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ahb_output_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_output_arbiter.sv
// Output-stage arbiter for one shared slave port of the AHB bus matrix.
// Chooses which input port owns the slave address phase, in round-robin or
// fixed-priority mode. The grant is frozen during locked transfers and
// during held bursts.
module ahb_output_arbiter #(
  parameter int NUM_PORTS        = 4,
  parameter int PORT_W           = $clog2(NUM_PORTS),
  parameter int ARB_MODE         = 0,
  parameter int EARLY_INCR_LIMIT = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 no_port,
  output logic                 burst_hold
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BU_SINGLE = 3'd0;
  localparam logic [2:0] BU_INCR   = 3'd1;
  localparam logic [2:0] BU_WRAP4  = 3'd2;
  localparam logic [2:0] BU_INCR4  = 3'd3;
  localparam logic [2:0] BU_WRAP8  = 3'd4;
  localparam logic [2:0] BU_INCR8  = 3'd5;
  localparam logic [2:0] BU_WRAP16 = 3'd6;
  localparam logic [2:0] BU_INCR16 = 3'd7;

  localparam logic [PORT_W:0] P_ONE = (PORT_W+1)'(1);
  localparam logic [PORT_W:0] P_NUM = (PORT_W+1)'(NUM_PORTS);

  logic [3:0]             r_remain;
  logic                   r_hold;
  logic [1:0]             r_early_cnt;
  logic [PORT_W-1:0]      r_port;
  logic                   r_no_port;

  logic [3:0]             w_remain_nxt;
  logic                   w_hold_nxt;
  logic [1:0]             w_early_nxt;
  logic [PORT_W-1:0]      w_port_nxt;
  logic                   w_no_port_nxt;

  logic [PORT_W:0]        w_base;
  logic [PORT_W:0]        w_off;
  logic [PORT_W:0]        w_sum;
  logic [2*NUM_PORTS-1:0] w_req2;
  logic [2*NUM_PORTS-1:0] w_rot2;
  logic                   w_found;

  // Burst tracking: beats remaining and whether the current burst holds the grant.
  always_comb begin
    w_remain_nxt = r_remain;
    w_hold_nxt   = r_hold;
    if (!HSELM) begin
      w_remain_nxt = 4'd0;
      w_hold_nxt   = 1'b0;
    end else begin
      case (HTRANSM)
        TR_IDLE: begin
          w_remain_nxt = 4'd0;
          w_hold_nxt   = 1'b0;
        end
        TR_BUSY: begin
          w_remain_nxt = r_remain;
          w_hold_nxt   = r_hold;
        end
        TR_NONSEQ: begin
          case (HBURSTM)
            BU_WRAP16, BU_INCR16: begin w_remain_nxt = 4'd14; w_hold_nxt = 1'b1; end
            BU_WRAP8,  BU_INCR8:  begin w_remain_nxt = 4'd6;  w_hold_nxt = 1'b1; end
            BU_WRAP4,  BU_INCR4:  begin w_remain_nxt = 4'd2;  w_hold_nxt = 1'b1; end
            BU_INCR: begin
              // After enough short INCR bursts in a row, INCR stops locking out others.
              if (r_early_cnt == 2'(EARLY_INCR_LIMIT)) begin
                w_remain_nxt = 4'd0;
                w_hold_nxt   = 1'b0;
              end else begin
                w_remain_nxt = 4'd2;
                w_hold_nxt   = 1'b1;
              end
            end
            default: begin w_remain_nxt = 4'd0; w_hold_nxt = 1'b0; end
          endcase
        end
        TR_SEQ: begin
          if (r_remain == 4'd0) begin
            w_remain_nxt = 4'd0;
            w_hold_nxt   = 1'b0;
          end else begin
            w_remain_nxt = r_remain - 4'd1;
            w_hold_nxt   = r_hold;
          end
        end
      endcase
    end
  end

  // Count back-to-back bursts started while a previous one was still holding.
  always_comb begin
    w_early_nxt = r_early_cnt;
    if (!w_hold_nxt)
      w_early_nxt = 2'd0;
    else if (r_hold && (HTRANSM == TR_NONSEQ))
      w_early_nxt = (r_early_cnt == 2'd3) ? 2'd3 : r_early_cnt + 2'd1;
  end

  // Port selection: rotate the request vector to the search start and take the first hit.
  always_comb begin
    w_base = '0;
    if (!r_no_port && (ARB_MODE == 0))
      w_base = {1'b0, r_port} + P_ONE;
    w_req2  = {req_port, req_port};
    w_rot2  = w_req2 >> w_base;
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!w_found && w_rot2[k]) begin
        w_found = 1'b1;
        w_off   = (PORT_W+1)'(k);
      end
    end
    w_sum = w_base + w_off;
    if (w_sum >= P_NUM)
      w_sum = w_sum - P_NUM;

    w_port_nxt    = r_port;
    w_no_port_nxt = r_no_port;
    if (HMASTLOCKM || w_hold_nxt) begin
      w_port_nxt    = r_port;
      w_no_port_nxt = r_no_port;
    end else if (w_found) begin
      w_port_nxt    = w_sum[PORT_W-1:0];
      w_no_port_nxt = 1'b0;
    end else if (!r_no_port && !HSELM) begin
      w_no_port_nxt = 1'b1;
    end
  end

  // State registers; everything advances only on ready cycles.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_remain    <= 4'd0;
      r_hold      <= 1'b0;
      r_early_cnt <= 2'd0;
      r_port      <= '0;
      r_no_port   <= 1'b1;
    end else if (HREADYM) begin
      r_remain    <= w_remain_nxt;
      r_hold      <= w_hold_nxt;
      r_early_cnt <= w_early_nxt;
      r_port      <= w_port_nxt;
      r_no_port   <= w_no_port_nxt;
    end
  end

  // One-hot grant decode, suppressed when nobody owns the port.
  always_comb begin
    grant = '0;
    if (!r_no_port)
      grant = NUM_PORTS'(1) << r_port;
  end

  assign addr_in_port = r_port;
  assign no_port      = r_no_port;
  assign burst_hold   = r_hold;

endmodule

// File: tb/tb_ahb_output_arbiter.sv
// Scoreboard bench for ahb_output_arbiter: three configurations share one
// stimulus stream (4-port round-robin, 4-port fixed priority, 3-port round-robin).
module tb_ahb_output_arbiter;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [3:0] req;
  logic       rdy, sel, lock;
  logic [1:0] tr;
  logic [2:0] bu;

  logic [1:0] a_port, b_port, c_port;
  logic [3:0] a_grant, b_grant;
  logic [2:0] c_grant;
  logic       a_nop, b_nop, c_nop, a_hold, b_hold, c_hold;

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct { int remain; bit hold; int early; int port; bit nop; } mst_t;
  typedef struct { mst_t a; mst_t b; mst_t c; } exp_t;
  exp_t q[$];
  mst_t ma, mb, mc;

  always #5 HCLK = ~HCLK;

  ahb_output_arbiter #(.NUM_PORTS(4), .ARB_MODE(0), .EARLY_INCR_LIMIT(1)) dut_rr (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req), .HREADYM(rdy), .HSELM(sel),
    .HTRANSM(tr), .HBURSTM(bu), .HMASTLOCKM(lock),
    .addr_in_port(a_port), .grant(a_grant), .no_port(a_nop), .burst_hold(a_hold));

  ahb_output_arbiter #(.NUM_PORTS(4), .ARB_MODE(1), .EARLY_INCR_LIMIT(2)) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req), .HREADYM(rdy), .HSELM(sel),
    .HTRANSM(tr), .HBURSTM(bu), .HMASTLOCKM(lock),
    .addr_in_port(b_port), .grant(b_grant), .no_port(b_nop), .burst_hold(b_hold));

  ahb_output_arbiter #(.NUM_PORTS(3), .ARB_MODE(0), .EARLY_INCR_LIMIT(3)) dut_r3 (
    .HCLK(HCLK), .HRESETn(HRESETn), .req_port(req[2:0]), .HREADYM(rdy), .HSELM(sel),
    .HTRANSM(tr), .HBURSTM(bu), .HMASTLOCKM(lock),
    .addr_in_port(c_port), .grant(c_grant), .no_port(c_nop), .burst_hold(c_hold));

  function automatic mst_t mrst();
    mst_t m;
    m.remain = 0; m.hold = 1'b0; m.early = 0; m.port = 0; m.nop = 1'b1;
    return m;
  endfunction

  // Reference model: burst length table plus a priority-ordered port search.
  function automatic mst_t mstep(mst_t m, int n, int mode, int limit, bit s,
                                 bit [1:0] t, bit [2:0] b, bit l, int r, bit y);
    mst_t x;
    int   start, p, len;
    bit   f;
    x = m;
    if (!y) return m;
    if (!s) begin
      x.remain = 0; x.hold = 1'b0;
    end else if (t == 2'b00) begin
      x.remain = 0; x.hold = 1'b0;
    end else if (t == 2'b10) begin
      if (b == 3'd0) begin
        x.remain = 0; x.hold = 1'b0;
      end else if (b == 3'd1) begin
        if (m.early == limit) begin x.remain = 0; x.hold = 1'b0; end
        else begin x.remain = 2; x.hold = 1'b1; end
      end else begin
        len = 4 << ((int'(b) - 2) / 2);
        x.remain = len - 2; x.hold = 1'b1;
      end
    end else if (t == 2'b11) begin
      if (m.remain == 0) begin x.remain = 0; x.hold = 1'b0; end
      else x.remain = m.remain - 1;
    end
    if (!x.hold) x.early = 0;
    else if (m.hold && t == 2'b10) x.early = (m.early >= 3) ? 3 : m.early + 1;
    if (!(l || x.hold)) begin
      start = (m.nop || mode == 1) ? 0 : m.port + 1;
      f = 1'b0;
      for (int k = 0; k < n; k++) begin
        p = (start + k) % n;
        if (!f && r[p]) begin f = 1'b1; x.port = p; x.nop = 1'b0; end
      end
      if (!f && !m.nop && !s) x.nop = 1'b1;
    end
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic chk_dut(input string tag, input mst_t e, input int port, input int nop,
                         input int grant, input int hold);
    chk({tag, ".port"},  port,  e.port);
    chk({tag, ".nop"},   nop,   int'(e.nop));
    chk({tag, ".grant"}, grant, e.nop ? 0 : (1 << e.port));
    chk({tag, ".hold"},  hold,  int'(e.hold));
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk_dut({tag, ".rr"}, e.a, int'(a_port), int'(a_nop), int'(a_grant), int'(a_hold));
    chk_dut({tag, ".fp"}, e.b, int'(b_port), int'(b_nop), int'(b_grant), int'(b_hold));
    chk_dut({tag, ".r3"}, e.c, int'(c_port), int'(c_nop), int'(c_grant), int'(c_hold));
  endtask

  // Monitor: after each rising edge, pop the expected state and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge HCLK);
      #1;
      if (mon_en) begin
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
        end else begin
          e = q.pop_front();
          chk_all("cyc", e);
        end
      end
    end
  end

  task automatic drv(input bit s, input bit [1:0] t, input bit [2:0] b, input bit l,
                     input bit [3:0] r, input bit y);
    @(negedge HCLK);
    HRESETn = 1'b1;
    sel = s; tr = t; bu = b; lock = l; req = r; rdy = y;
    ma = mstep(ma, 4, 0, 1, s, t, b, l, int'(r), y);
    mb = mstep(mb, 4, 1, 2, s, t, b, l, int'(r), y);
    mc = mstep(mc, 3, 0, 3, s, t, b, l, int'(r[2:0]), y);
    q.push_back('{ma, mb, mc});
    mon_en = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    q.delete();
    HRESETn = 1'b0;
    ma = mrst(); mb = mrst(); mc = mrst();
    #1;
    chk_all("async_rst", '{ma, mb, mc});
    q.push_back('{ma, mb, mc});
  endtask

  // Stimulus: directed scenarios, then a randomized legal-ish AHB stream.
  initial begin
    int left;
    bit prv_y, y, s, l;
    bit [1:0] t;
    bit [2:0] b;
    bit [3:0] r;
    HRESETn = 1'b0;
    req = '0; rdy = 1'b1; sel = 1'b0; lock = 1'b0; tr = 2'b00; bu = 3'd0;
    ma = mrst(); mb = mrst(); mc = mrst();
    repeat (2) @(posedge HCLK);
    #1;
    chk_all("reset", '{ma, mb, mc});

    // Rotation / fixed priority with SINGLE NONSEQ traffic.
    repeat (6) drv(1, 2'b10, 3'd0, 0, 4'b1010, 1);
    repeat (4) drv(1, 2'b10, 3'd0, 0, 4'b1110, 1);
    drv(1, 2'b10, 3'd0, 0, 4'b0100, 0);
    // INCR8 from port 0 with port 2 waiting, including a wait state and BUSY.
    drv(1, 2'b10, 3'd0, 0, 4'b0001, 1);
    drv(1, 2'b10, 3'd5, 0, 4'b0101, 1);
    drv(1, 2'b11, 3'd5, 0, 4'b0101, 1);
    drv(1, 2'b11, 3'd5, 0, 4'b0101, 0);
    drv(1, 2'b01, 3'd5, 0, 4'b0101, 1);
    repeat (6) drv(1, 2'b11, 3'd5, 0, 4'b0101, 1);
    drv(1, 2'b00, 3'd0, 0, 4'b0101, 1);
    // Locked SINGLE transfers, then unlocked.
    repeat (3) drv(1, 2'b10, 3'd0, 1, 4'b1110, 1);
    repeat (2) drv(1, 2'b10, 3'd0, 0, 4'b1110, 1);
    // Back-to-back 2-beat INCR bursts from port 0, port 1 requesting.
    drv(1, 2'b10, 3'd0, 0, 4'b0001, 1);
    repeat (3) begin
      drv(1, 2'b10, 3'd1, 0, 4'b0011, 1);
      drv(1, 2'b11, 3'd1, 0, 4'b0011, 1);
    end
    // Idle retention, then deselect with no requests.
    repeat (2) drv(1, 2'b00, 3'd0, 0, 4'b0000, 1);
    repeat (2) drv(0, 2'b00, 3'd0, 0, 4'b0000, 1);

    left = 0; prv_y = 1'b1; t = 2'b00; b = 3'd0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset();
        left = 0;
      end
      y = ($urandom_range(0, 3) != 0);
      if (prv_y) begin
        if (left > 0) begin
          if ($urandom_range(0, 5) == 0) t = 2'b01;
          else begin t = 2'b11; left--; end
        end else if ($urandom_range(0, 7) == 0) begin
          t = 2'b00;
        end else begin
          t = 2'b10;
          b = 3'($urandom_range(0, 7));
          if (b == 3'd0) left = 0;
          else if (b == 3'd1) left = $urandom_range(0, 3);
          else left = (4 << ((int'(b) - 2) / 2)) - 1;
        end
      end
      s = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 11) == 0);
      r = 4'($urandom_range(0, 15));
      drv(s, t, b, l, r, y);
      prv_y = y;
    end

    @(posedge HCLK);
    #2;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
